// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the RV32 pipeline control path
//
// Purpose: hazard FSM state type, the bundled pipeline-register control word
// and the fixed control patterns used by hazard_ctrl.
// Ports: none (package).
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hazard_state_e;

    // Control word driven to the PC and the pipeline registers.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_hold;
        logic mem_wb_bubble;
    } hazard_ctrl_t;

    // NOP control: every bubble/flush path loads zero control, nothing advances.
    localparam hazard_ctrl_t HZ_CTRL_NOP    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    // Whole-pipeline freeze while data memory is busy or hung.
    localparam hazard_ctrl_t HZ_CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    // Taken branch: fetch from the target and squash IF/ID and ID/EX.
    localparam hazard_ctrl_t HZ_CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
    localparam hazard_ctrl_t HZ_CTRL_LDUSE  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam hazard_ctrl_t HZ_CTRL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare
//
// Purpose: flags when the instruction in ID reads the destination of a load in EX.
// Ports:
//   ex_mem_read_i        EX instruction is a load
//   ex_rd_i[4:0]         EX destination register
//   id_rs1_i/id_rs2_i    ID source registers
//   id_uses_rs1_i/rs2_i  ID instruction really reads the source
//   load_use_o           hazard detected
module load_use_detect (
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign load_use_o = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, freeze and memory-timeout control
//
// Purpose: drives PC / IF/ID / ID/EX / EX/MEM / MEM/WB enables from load-use,
// taken-branch and data-memory status; escalates a hung access to a sticky fault.
// Optional feature macro: HAZARD_PERF_EN (adds stall_cycles / flush_count).
// Ports:
//   clock, reset                   clock, synchronous active-high reset
//   id_rs1, id_rs2, id_uses_rs*    ID-stage source operands
//   ex_mem_read, ex_rd             EX-stage load and destination
//   ex_branch_taken                EX-stage taken branch/jump
//   mem_req, mem_ready             MEM-stage data memory handshake
//   pc_write .. mem_wb_bubble      pipeline register controls
//   mem_fault                      sticky memory-timeout fault
//   stall_cycles, flush_count      perf counters (HAZARD_PERF_EN only)
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        pipe_hold,
    output logic        mem_wb_bubble,
    output logic        mem_fault
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    // Stall cycle number MEM_TIMEOUT is seen with this count; it is the last one.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    hazard_state_e state_q, state_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;

    logic         in_fault;
    logic         mem_stall;
    logic         load_use;
    hazard_ctrl_t ctrl;

    load_use_detect u_load_use_detect (
        .ex_mem_read_i (ex_mem_read),
        .ex_rd_i       (ex_rd),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .load_use_o    (load_use)
    );

    assign in_fault  = (state_q == FAULT);
    assign mem_stall = !in_fault && mem_req && !mem_ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A branch or load-use hidden behind a freeze is re-presented by the held
    // EX/ID registers and acts in the first unfrozen cycle.
    always_comb begin
        if (reset) begin
            ctrl = HZ_CTRL_NOP;
        end else if (in_fault || mem_stall) begin
            ctrl = HZ_CTRL_FREEZE;
        end else if (ex_branch_taken) begin
            ctrl = HZ_CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = HZ_CTRL_LDUSE;
        end else begin
            ctrl = HZ_CTRL_NORMAL;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign pipe_hold     = ctrl.pipe_hold;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign mem_fault     = !reset && in_fault;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;
    logic        count_stall;
    logic        count_flush;

    // Only the action actually taken is counted: a load-use shadowed by a
    // branch is squashed, and a branch shadowed by a freeze has not flushed yet.
    assign count_stall = !in_fault && (mem_stall || (!ex_branch_taken && load_use));
    assign count_flush = !in_fault && !mem_stall && ex_branch_taken;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            if (count_stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (count_flush) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    // Perf counters not built.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int MT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic        mem_req, mem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic        pipe_hold, mem_wb_bubble, mem_fault;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    always #5 clock = ~clock;

    hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .pipe_hold       (pipe_hold),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_fault       (mem_fault)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    typedef struct {
        logic [6:0]  ctrl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    // Reference model: consecutive memory-stall run length and sticky fault.
    int          m_run   = 0;
    bit          m_fault = 1'b0;
    logic [31:0] m_sc    = 32'd0;
    logic [31:0] m_fc    = 32'd0;

    // One cycle: drive inputs after the edge, push the expected response,
    // then advance the model across the coming edge.
    task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                        input logic br, input logic req, input logic rdy);
        exp_t e;
        bit   lu, stall;
        @(posedge clock);
        #1;
        reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
        lu    = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        stall = !m_fault && req && !rdy;
        // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_wb_bubble, mem_fault}
        if (rst)          e.ctrl = 7'b0011010;
        else if (m_fault) e.ctrl = 7'b0000111;
        else if (stall)   e.ctrl = 7'b0000110;
        else if (br)      e.ctrl = 7'b1111000;
        else if (lu)      e.ctrl = 7'b0001000;
        else              e.ctrl = 7'b1100000;
        e.sc = m_sc;
        e.fc = m_fc;
        exp_q.push_back(e);
        if (rst) begin
            m_run = 0; m_fault = 1'b0; m_sc = 32'd0; m_fc = 32'd0;
        end else if (!m_fault) begin
            if (stall || (!br && lu)) m_sc = m_sc + 32'd1;
            if (!stall && br)         m_fc = m_fc + 32'd1;
            if (stall) begin
                m_run = m_run + 1;
                if (m_run == MT) m_fault = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [6:0] got;
            e   = exp_q.pop_front();
            got = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_wb_bubble, mem_fault};
            total++;
            if (got === e.ctrl) passed++;
            else $display("FAIL ctrl at %0t: got %b expected %b", $time, got, e.ctrl);
`ifdef HAZARD_PERF_EN
            total++;
            if (stall_cycles === e.sc) passed++;
            else $display("FAIL stall_cycles at %0t: got %0d expected %0d", $time, stall_cycles, e.sc);
            total++;
            if (flush_count === e.fc) passed++;
            else $display("FAIL flush_count at %0t: got %0d expected %0d", $time, flush_count, e.fc);
`endif
        end
    end

    initial begin
        int fault_age;
        reset = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clock);

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 5, 5, 1, 1, 1, 5, 1, 1, 0);
        // Load-use on rs1, then load moves to MEM
        step(0, 5, 0, 1, 0, 1, 5, 0, 0, 1);
        step(0, 5, 0, 1, 0, 0, 7, 0, 1, 1);
        // Load to x0: no stall; rs2 match; unused-operand match
        step(0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 1, 9, 0, 1, 1, 9, 0, 0, 1);
        step(0, 9, 1, 0, 0, 1, 9, 0, 0, 1);
        // Branch overrides load-use
        step(0, 5, 0, 1, 0, 1, 5, 1, 0, 1);
        // Three stall cycles then ready
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // Branch during freeze flushes only after release
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Hung memory: fault from cycle MT+1, sticky until reset
        repeat (6) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) step(0, 3, 0, 1, 0, 1, 3, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Exactly MT-1 stalls stays out of fault
        repeat (MT - 1) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        fault_age = 0;
        for (int i = 0; i < 1500; i++) begin
            logic rst;
            fault_age = m_fault ? fault_age + 1 : 0;
            rst = ($urandom_range(0, 99) < 2) || (fault_age > 3 && $urandom_range(0, 1) == 1);
            step(rst, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 60));
        end

        repeat (2) @(negedge clock);
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit for the 5-stage RV32 core: it drives the write-enable, hold, bubble and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards and taken branches, and freezes the whole pipeline while the data memory is not ready. A timeout FSM escalates a hung memory access to a sticky fault. It sits beside the datapath in the core top and consumes only decode, EX and MEM-stage status.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive memory-stall cycles that trigger FAULT; legal range 2..255.

Ports (reset is synchronous, active-high; single clock):
- clock  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- id_rs1, id_rs2  in  5  source register indices of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- mem_req  in  1  instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register update enable
- if_id_write  out  1  IF/ID write enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble  out  1  load zero control into ID/EX
- pipe_hold  out  1  hold ID/EX, EX/MEM contents
- mem_wb_bubble  out  1  load zero control into MEM/WB
- mem_fault  out  1  sticky memory-timeout fault

## Operation
- State machine: RUN, MEM_WAIT, FAULT. Wait counter wait_cnt is 8 bits.
- mem_stall is asserted when (RUN or MEM_WAIT) and mem_req and !mem_ready.
- RUN: mem_stall goes to MEM_WAIT and sets wait_cnt=1. Otherwise the FSM stays in RUN.
- MEM_WAIT: mem_ready returns to RUN and clears wait_cnt. On !mem_ready with wait_cnt==MEM_TIMEOUT-1, go to FAULT. Otherwise wait_cnt increments.
- FAULT: absorbing until reset.
- load_use is asserted when ex_mem_read and ex_rd!=0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
- Output priority: reset > FAULT > mem_stall > ex_branch_taken > load_use > normal.
- Reset: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pipe_hold=0, mem_wb_bubble=1, mem_fault=0.
- FAULT or mem_stall (freeze): pc_write=0, if_id_write=0, pipe_hold=1, mem_wb_bubble=1, if_id_flush=0, id_ex_bubble=0. mem_fault=1 only in FAULT.
- Taken branch: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, pipe_hold=0. Load-use is ignored because the ID instruction is squashed.
- Load-use: pc_write=0, if_id_write=0, id_ex_bubble=1. All other outputs are at normal values.
- Normal: pc_write=1, if_id_write=1, all other outputs 0.
- A branch or load-use that coincides with a freeze is not lost. EX/ID contents are held, so it re-evaluates and acts in the first unfrozen cycle.

## Timing
- All outputs are combinational from the current state and inputs. Zero-cycle latency from hazard to control.
- Load-use costs exactly 1 bubble cycle. The next cycle, the load is in MEM and load_use deasserts.
- Taken branch costs 2 flushed slots (IF/ID, ID/EX) in one cycle.
- Memory wait: the freeze lasts exactly while mem_ready is low. Release happens in the same cycle mem_ready rises.
- FAULT is entered on the edge ending the MEM_TIMEOUT-th consecutive stalled cycle. mem_fault is high from the next cycle.
- Reset asserted mid-stall or in FAULT returns the FSM to RUN with wait_cnt=0 on the next edge. It also clears all counters.

## Configuration
- HAZARD_PERF_EN defined adds two 32-bit outputs, stall_cycles and flush_count. Both reset to 0.
- stall_cycles increments on every freeze or load-use cycle.
- flush_count increments on every taken-branch flush.
- Both counters wrap modulo 2^32 and do not count in FAULT.
- HAZARD_PERF_EN undefined: ports and counters are absent, and behaviour is otherwise identical.

## Structure
- cpu_pkg gains: hazard_state_e enum (RUN, MEM_WAIT, FAULT); hazard_ctrl_t struct bundling the six control outputs, for wiring to the pipeline registers; NOP-control constant reused by the flush/bubble paths.
- One sub-module, load_use_detect, is purely combinational: register compare producing load_use.

## Test plan
- EX: lw x5 (ex_mem_read=1, ex_rd=5); ID: id_rs1=5, id_uses_rs1=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1. Same case with ex_rd=0 -> no stall.
- ex_branch_taken=1 while load_use also true -> if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1.
- mem_req=1, mem_ready low 3 cycles then high (MEM_TIMEOUT=4) -> pipe_hold=1 for 3 cycles, RUN on the 4th, mem_fault stays 0.
- MEM_TIMEOUT=4, mem_ready held low -> mem_fault=1 from cycle 5, remains with mem_ready later high, cleared only by reset.
- ex_branch_taken=1 during freeze -> no flush while frozen; flush in the first cycle after mem_ready=1.
- HAZARD_PERF_EN: 1 load-use + 3 mem-stall cycles + 2 branches -> stall_cycles=4, flush_count=2; reset -> both 0.
